full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 19 +
 rtl/full_adder_if.sv | 26 ++
 rtl/full_adder_cell.sv | 13 +
 rtl/full_adder.sv | 70 +++++++
 tb/tb_full_adder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/full_adder_pkg.sv
// Shared arithmetic definitions for the registered adder family:
// width limits, reset values and the width legality helper.
package full_adder_pkg;

    // Widest operand any adder instance in the library may be built with.
    localparam int ADDER_MAX_WIDTH = 64;

    // Value loaded into the sum register on reset; sliced to the instance width.
    localparam logic [ADDER_MAX_WIDTH-1:0] ADDER_RST_SUM = '0;

    // Value loaded into the carry-out register on reset.
    localparam logic ADDER_RST_CARRY = 1'b0;

    // True when w is a width the adder can be elaborated with.
    function automatic bit adder_width_ok(input int w);
        return (w >= 1) && (w <= ADDER_MAX_WIDTH);
    endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered adder.
// The master drives the operands and the input strobe.
// The slave (the adder) returns the registered sum, the carry and the output strobe.
interface full_adder_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic             e;
    logic             out_valid;

    modport master (
        output a, b, c, in_valid,
        input  d, e, out_valid
    );

    modport slave (
        input  a, b, c, in_valid,
        output d, e, out_valid
    );

endinterface : full_adder_if

// File: rtl/full_adder_cell.sv
// One-bit combinational full-adder cell. Carry-out is the majority of the three inputs.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {e, d} = a + b + c, one cycle after the operands are sampled.
// The inputs drive a chain of WIDTH full_adder_cell instances.
// The sum, carry and valid outputs come straight from flops.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    full_adder_if.slave bus
);

    // Reject widths the library does not support before anything else is built.
    if (!adder_width_ok(WIDTH)) begin : g_bad_width
        $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
    end

    // Carry chain: k[0] is the carry-in and k[WIDTH] is the carry-out.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] d_q, d_d;
    logic             e_q, e_d;
    logic             out_valid_q, out_valid_d;

    assign k[0] = bus.c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (k[i]),
            .s    (s[i]),
            .cout (k[i+1])
        );
    end

    // Next state: capture a new result on in_valid; otherwise hold the data and drop valid.
    always_comb begin
        // NOTE: every output of this block gets a default first, so that no path through the block leaves a value unassigned and infers a latch.
        d_d         = d_q;
        e_d         = e_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            d_d         = s;
            e_d         = k[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    // Output registers. Reset is synchronous and overrides any result arriving on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every flop samples values from before the edge.
        if (rst) begin
            d_q         <= ADDER_RST_SUM[WIDTH-1:0];
            e_q         <= ADDER_RST_CARRY;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            e_q         <= e_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.d         = d_q;
    assign bus.e         = e_q;
    assign bus.out_valid = out_valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed and randomised bench for full_adder.
// Three instances are built, at WIDTH 1, 8 and 16; they share clk and rst.
module tb_full_adder;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    full_adder_if #(.WIDTH(1))  if1  ();
    full_adder_if #(.WIDTH(8))  if8  ();
    full_adder_if #(.WIDTH(16)) if16 ();

    full_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
    full_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    full_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    // 20 ns clock period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Watchdog: stops the run if the stimulus never completes.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so the outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  vec_abc [8];
        logic [1:0]  vec_de  [8];
        logic [15:0] ra, rb;
        logic        rc, rv, rr;
        logic [16:0] full;
        logic [15:0] exp_d;
        logic        exp_e, exp_v;

        vec_abc = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
        vec_de  = '{2'b00,  2'b10,  2'b10,  2'b01,  2'b10,  2'b01,  2'b01,  2'b11};

        rst = 1'b1;
        if1.a = '0;  if1.b = '0;  if1.c = 1'b0;  if1.in_valid = 1'b0;
        if8.a = '0;  if8.b = '0;  if8.c = 1'b0;  if8.in_valid = 1'b0;
        if16.a = '0; if16.b = '0; if16.c = 1'b0; if16.in_valid = 1'b0;

        // Reset state of all three instances
        tick();
        tick();
        check("rst_d1",  64'(if1.d),  64'h0);
        check("rst_e1",  64'(if1.e),  64'h0);
        check("rst_v1",  64'(if1.out_valid), 64'h0);
        check("rst_d8",  64'(if8.d),  64'h0);
        check("rst_v8",  64'(if8.out_valid), 64'h0);
        check("rst_d16", 64'(if16.d), 64'h0);
        check("rst_v16", 64'(if16.out_valid), 64'h0);

        // After release with no valid input, the outputs stay 0/0/0.
        rst = 1'b0;
        tick();
        check("idle_d1", 64'(if1.d), 64'h0);
        check("idle_e1", 64'(if1.e), 64'h0);
        check("idle_v1", 64'(if1.out_valid), 64'h0);

        // Exhaustive width-1 sweep
        if1.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if1.a = vec_abc[i][2];
            if1.b = vec_abc[i][1];
            if1.c = vec_abc[i][0];
            tick();
            check($sformatf("sweep%0d_d", i), 64'(if1.d), 64'(vec_de[i][1]));
            check($sformatf("sweep%0d_e", i), 64'(if1.e), 64'(vec_de[i][0]));
            check($sformatf("sweep%0d_v", i), 64'(if1.out_valid), 64'h1);
        end

        // Reset held for 2 cycles overrides a valid 1+1+1.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rstpri%0d_d", i), 64'(if1.d), 64'h0);
            check($sformatf("rstpri%0d_e", i), 64'(if1.e), 64'h0);
            check($sformatf("rstpri%0d_v", i), 64'(if1.out_valid), 64'h0);
        end
        rst = 1'b0;
        tick();
        check("rel_d", 64'(if1.d), 64'h1);
        check("rel_e", 64'(if1.e), 64'h1);
        check("rel_v", 64'(if1.out_valid), 64'h1);
        if1.in_valid = 1'b0;

        // Hold behaviour, WIDTH=8
        if8.a = 8'h0F; if8.b = 8'h01; if8.c = 1'b0; if8.in_valid = 1'b1;
        tick();
        check("hold_load_d", 64'(if8.d), 64'h10);
        check("hold_load_e", 64'(if8.e), 64'h0);
        check("hold_load_v", 64'(if8.out_valid), 64'h1);
        if8.in_valid = 1'b0; if8.a = 8'hAA; if8.b = 8'h77; if8.c = 1'b1;
        tick();
        check("hold_d", 64'(if8.d), 64'h10);
        check("hold_e", 64'(if8.e), 64'h0);
        check("hold_v", 64'(if8.out_valid), 64'h0);

        // Carry ripple and overflow
        if8.a = 8'hFF; if8.b = 8'h00; if8.c = 1'b1; if8.in_valid = 1'b1;
        tick();
        check("ripple_d", 64'(if8.d), 64'h00);
        check("ripple_e", 64'(if8.e), 64'h1);
        if8.a = 8'hFF; if8.b = 8'hFF; if8.c = 1'b1;
        tick();
        check("ovf_d", 64'(if8.d), 64'hFF);
        check("ovf_e", 64'(if8.e), 64'h1);

        // Back-to-back throughput
        if8.a = 8'h01; if8.b = 8'h02; if8.c = 1'b0;
        tick();
        check("b2b0_d", 64'(if8.d), 64'h03);
        check("b2b0_e", 64'(if8.e), 64'h0);
        check("b2b0_v", 64'(if8.out_valid), 64'h1);
        if8.a = 8'h80; if8.b = 8'h80; if8.c = 1'b0;
        tick();
        check("b2b1_d", 64'(if8.d), 64'h00);
        check("b2b1_e", 64'(if8.e), 64'h1);
        check("b2b1_v", 64'(if8.out_valid), 64'h1);
        if8.a = 8'h7F; if8.b = 8'h00; if8.c = 1'b1;
        tick();
        check("b2b2_d", 64'(if8.d), 64'h80);
        check("b2b2_e", 64'(if8.e), 64'h0);
        check("b2b2_v", 64'(if8.out_valid), 64'h1);
        if8.in_valid = 1'b0;
        tick();
        check("b2b_end_v", 64'(if8.out_valid), 64'h0);

        // Random compare, WIDTH=16, with occasional reset pulses
        exp_d = 16'(if16.d);
        exp_e = 1'b0;
        exp_v = 1'b0;
        rst = 1'b1;
        tick();
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 49) == 0);
            if16.a = ra; if16.b = rb; if16.c = rc; if16.in_valid = rv;
            rst = rr;
            tick();
            if (rr) begin
                exp_d = '0; exp_e = 1'b0; exp_v = 1'b0;
            end else if (rv) begin
                full  = 17'(ra) + 17'(rb) + 17'(rc);
                exp_d = full[15:0];
                exp_e = full[16];
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            check($sformatf("rnd%0d_d", n), 64'(if16.d), 64'(exp_d));
            check($sformatf("rnd%0d_e", n), 64'(if16.e), 64'(exp_e));
            check($sformatf("rnd%0d_v", n), 64'(if16.out_valid), 64'(exp_v));
        end
        rst = 1'b0;
        if16.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_full_adder
